// File: rtl/cmd_sequencer_if.sv
// Host-command and CMD physical-layer signals of one cmd_sequencer.
// master = the sequencer itself; slave = host register block plus physical layer.
interface cmd_sequencer_if;
   logic        start_cmd;
   logic [5:0]  cmd_index;
   logic [31:0] cmd_arg;
   logic [1:0]  resp_type;
   logic        phys_inactive;
   logic        phys_ACK;
   logic        phys_REQ;
   logic        phys_timeout;
   logic [47:0] phys_response;
   logic        new_cmd;
   logic [37:0] cmd_index_arg;
   logic        REQ_to_phys;
   logic        ACK_to_phys;
   logic        busy;
   logic        cmd_complete;
   logic [31:0] resp_data;
   logic        err_timeout;
   logic        err_crc;
   logic        err_index;
   logic        err_endbit;
   logic        err_hang;
   logic [2:0]  state_dbg;

   modport master (
      input  start_cmd, cmd_index, cmd_arg, resp_type,
      input  phys_inactive, phys_ACK, phys_REQ, phys_timeout, phys_response,
      output new_cmd, cmd_index_arg, REQ_to_phys, ACK_to_phys, busy, cmd_complete,
      output resp_data, err_timeout, err_crc, err_index, err_endbit, err_hang, state_dbg
   );

   modport slave (
      output start_cmd, cmd_index, cmd_arg, resp_type,
      output phys_inactive, phys_ACK, phys_REQ, phys_timeout, phys_response,
      input  new_cmd, cmd_index_arg, REQ_to_phys, ACK_to_phys, busy, cmd_complete,
      input  resp_data, err_timeout, err_crc, err_index, err_endbit, err_hang, state_dbg
   );
endinterface

// File: rtl/cmd_sequencer.sv
// Runs one SD command through the CMD physical layer: launch, REQ/ACK handshakes,
// response capture, serial CRC7/index/end-bit checks, retries and status reporting.
module cmd_sequencer #(
   parameter int MAX_RETRY = 2,
   parameter int WATCHDOG  = 255
) (
   input logic             CLK_SD_card,
   input logic             reset,
   cmd_sequencer_if.master bus
);
   localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam int WW = (WATCHDOG > 1) ? $clog2(WATCHDOG + 1) : 1;
   localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
   localparam logic [WW-1:0] WD_LAST   = WW'(WATCHDOG - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LAUNCH, S_HANDSHAKE, S_WAIT_RESP, S_TIMEOUT, S_CAPTURE, S_CHECK, S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [5:0]    index_q, index_d;
   logic [1:0]    rtype_q, rtype_d;
   logic [37:0]   cia_q, cia_d;
   logic [47:0]   frame_q, frame_d;
   logic [6:0]    crc_q, crc_d;
   logic [5:0]    bit_q, bit_d;
   logic [RW-1:0] retry_q, retry_d;
   logic [WW-1:0] wd_q, wd_d;
   logic          inact_prev_q, inact_prev_d;
   logic          new_cmd_q, new_cmd_d;
   logic          req_q, req_d;
   logic          ack_q, ack_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [31:0]   resp_q, resp_d;
   logic          e_to_q, e_to_d;
   logic          e_crc_q, e_crc_d;
   logic          e_idx_q, e_idx_d;
   logic          e_end_q, e_end_d;
   logic          e_hang_q, e_hang_d;

   logic crc_fb, crc_bad, end_bad, idx_bad, chk_en, retry_left;

   // Handshakes: each request output (new_cmd, REQ_to_phys, ACK_to_phys) is a registered
   // level held until its terminating input is sampled, then dropped on the next cycle.
   always_comb begin
      state_d      = state_q;
      index_d      = index_q;
      rtype_d      = rtype_q;
      cia_d        = cia_q;
      frame_d      = frame_q;
      crc_d        = crc_q;
      bit_d        = bit_q;
      retry_d      = retry_q;
      wd_d         = wd_q;
      inact_prev_d = bus.phys_inactive;
      new_cmd_d    = new_cmd_q;
      req_d        = req_q;
      ack_d        = ack_q;
      done_d       = 1'b0;
      resp_d       = resp_q;
      e_to_d       = e_to_q;
      e_crc_d      = e_crc_q;
      e_idx_d      = e_idx_q;
      e_end_d      = e_end_q;
      e_hang_d     = e_hang_q;

      chk_en     = rtype_q[0];
      crc_fb     = frame_q[6'd47 - bit_q] ^ crc_q[6];
      crc_bad    = chk_en & (crc_q != frame_q[7:1]);
      end_bad    = ~frame_q[0] | (frame_q[47:46] != 2'b00);
      idx_bad    = chk_en & (frame_q[45:40] != index_q);
      retry_left = (retry_q < RETRY_MAX);

      case (state_q)
         S_IDLE: begin
            if (bus.start_cmd) begin
               index_d   = bus.cmd_index;
               rtype_d   = bus.resp_type;
               cia_d     = {bus.cmd_index, bus.cmd_arg};
               frame_d   = '0;
               retry_d   = '0;
               e_to_d    = 1'b0;
               e_crc_d   = 1'b0;
               e_idx_d   = 1'b0;
               e_end_d   = 1'b0;
               e_hang_d  = 1'b0;
               new_cmd_d = 1'b1;
               state_d   = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            if (!bus.phys_inactive) begin
               new_cmd_d = 1'b0;
               req_d     = 1'b1;
               state_d   = S_HANDSHAKE;
            end
         end
         S_HANDSHAKE: begin
            if (bus.phys_ACK) begin
               req_d   = 1'b0;
               wd_d    = '0;
               state_d = S_WAIT_RESP;
            end
         end
         S_WAIT_RESP: begin
            // A response beats a coincident timeout.
            if (bus.phys_REQ) begin
               frame_d = bus.phys_response;
               ack_d   = 1'b1;
               state_d = S_CAPTURE;
            end else if (bus.phys_timeout || (bus.phys_inactive && !inact_prev_q)) begin
               state_d = S_TIMEOUT;
            end else if (wd_q == WD_LAST) begin
               e_hang_d = 1'b1;
               resp_d   = frame_q[39:8];
               done_d   = 1'b1;
               state_d  = S_DONE;
            end else begin
               wd_d = wd_q + WW'(1);
            end
         end
         S_TIMEOUT: begin
            if (rtype_q == 2'b00) begin
               resp_d  = frame_q[39:8];
               done_d  = 1'b1;
               state_d = S_DONE;
            end else if (retry_left) begin
               retry_d   = retry_q + RW'(1);
               new_cmd_d = 1'b1;
               state_d   = S_LAUNCH;
            end else begin
               e_to_d  = 1'b1;
               resp_d  = frame_q[39:8];
               done_d  = 1'b1;
               state_d = S_DONE;
            end
         end
         S_CAPTURE: begin
            if (!bus.phys_REQ) begin
               ack_d   = 1'b0;
               bit_d   = '0;
               crc_d   = '0;
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            // 40 serial CRC7 steps over frame[47:8], then one compare cycle.
            if (bit_q != 6'd40) begin
               crc_d = {crc_q[5:0], 1'b0} ^ (crc_fb ? 7'h09 : 7'h00);
               bit_d = bit_q + 6'd1;
            end else if (crc_bad && retry_left) begin
               retry_d   = retry_q + RW'(1);
               new_cmd_d = 1'b1;
               state_d   = S_LAUNCH;
            end else begin
               e_crc_d = crc_bad;
               e_idx_d = idx_bad;
               e_end_d = end_bad;
               resp_d  = frame_q[39:8];
               done_d  = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge CLK_SD_card or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         index_q      <= '0;
         rtype_q      <= '0;
         cia_q        <= '0;
         frame_q      <= '0;
         crc_q        <= '0;
         bit_q        <= '0;
         retry_q      <= '0;
         wd_q         <= '0;
         inact_prev_q <= 1'b0;
         new_cmd_q    <= 1'b0;
         req_q        <= 1'b0;
         ack_q        <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         resp_q       <= '0;
         e_to_q       <= 1'b0;
         e_crc_q      <= 1'b0;
         e_idx_q      <= 1'b0;
         e_end_q      <= 1'b0;
         e_hang_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         index_q      <= index_d;
         rtype_q      <= rtype_d;
         cia_q        <= cia_d;
         frame_q      <= frame_d;
         crc_q        <= crc_d;
         bit_q        <= bit_d;
         retry_q      <= retry_d;
         wd_q         <= wd_d;
         inact_prev_q <= inact_prev_d;
         new_cmd_q    <= new_cmd_d;
         req_q        <= req_d;
         ack_q        <= ack_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         resp_q       <= resp_d;
         e_to_q       <= e_to_d;
         e_crc_q      <= e_crc_d;
         e_idx_q      <= e_idx_d;
         e_end_q      <= e_end_d;
         e_hang_q     <= e_hang_d;
      end
   end

   assign bus.new_cmd       = new_cmd_q;
   assign bus.cmd_index_arg = cia_q;
   assign bus.REQ_to_phys   = req_q;
   assign bus.ACK_to_phys   = ack_q;
   assign bus.busy          = busy_q;
   assign bus.cmd_complete  = done_q;
   assign bus.resp_data     = resp_q;
   assign bus.err_timeout   = e_to_q;
   assign bus.err_crc       = e_crc_q;
   assign bus.err_index     = e_idx_q;
   assign bus.err_endbit    = e_end_q;
   assign bus.err_hang      = e_hang_q;
   assign bus.state_dbg     = state_q;
endmodule

// File: tb/tb_cmd_sequencer.sv
// Directed bench for cmd_sequencer: a scripted physical layer answers each command and
// every scenario task checks completion timing, status flags and response data inline.
module tb_cmd_sequencer;
   logic CLK_SD_card;
   logic reset;

   cmd_sequencer_if bus_if ();

   cmd_sequencer #(.MAX_RETRY(2), .WATCHDOG(8)) dut (
      .CLK_SD_card (CLK_SD_card),
      .reset       (reset),
      .bus         (bus_if)
   );

   initial CLK_SD_card = 1'b0;
   always #5 CLK_SD_card = ~CLK_SD_card;

   int compared = 0;
   int mismatched = 0;
   int launch_cnt = 0;
   logic new_cmd_prev = 1'b0;
   logic [4:0] errs;

   // {timeout, crc, index, endbit, hang}
   assign errs = {bus_if.err_timeout, bus_if.err_crc, bus_if.err_index,
                  bus_if.err_endbit, bus_if.err_hang};

   always @(posedge CLK_SD_card) begin
      new_cmd_prev <= bus_if.new_cmd;
      if (bus_if.new_cmd === 1'b1 && new_cmd_prev !== 1'b1) launch_cnt <= launch_cnt + 1;
   end

   // CRC7 by polynomial long division of data*x^7 by x^7+x^3+1.
   function automatic logic [6:0] crc7_of(input logic [39:0] data);
      logic [46:0] r;
      r = {data, 7'b0};
      for (int i = 46; i >= 7; i--)
         if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
      return r[6:0];
   endfunction

   function automatic logic [47:0] make_frame(input logic [5:0] idx, input logic [31:0] body,
                                              input logic endbit);
      logic [39:0] d;
      d = {2'b00, idx, body};
      return {d, crc7_of(d), endbit};
   endfunction

   task automatic wait_fail(input string what);
      compared++;
      mismatched++;
      $display("FAIL wait_%s: got no event within bound, want event", what);
   endtask

   task automatic accept(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt);
      bus_if.cmd_index = idx;
      bus_if.cmd_arg   = arg;
      bus_if.resp_type = rt;
      bus_if.start_cmd = 1'b1;
      @(negedge CLK_SD_card);
      bus_if.start_cmd = 1'b0;
   endtask

   // Physical layer: take new_cmd, leave idle, answer REQ_to_phys with ACK.
   task automatic phys_launch();
      int n;
      n = 0;
      while (bus_if.new_cmd !== 1'b1 && n < 100) begin @(negedge CLK_SD_card); n++; end
      if (bus_if.new_cmd !== 1'b1) begin wait_fail("new_cmd"); return; end
      bus_if.phys_inactive = 1'b0;
      n = 0;
      while (bus_if.REQ_to_phys !== 1'b1 && n < 20) begin @(negedge CLK_SD_card); n++; end
      if (bus_if.REQ_to_phys !== 1'b1) begin wait_fail("req_high"); return; end
      bus_if.phys_ACK = 1'b1;
      n = 0;
      do begin @(negedge CLK_SD_card); n++; end while (bus_if.REQ_to_phys !== 1'b0 && n < 20);
      bus_if.phys_ACK = 1'b0;
      if (bus_if.REQ_to_phys !== 1'b0) wait_fail("req_low");
   endtask

   // Returns at the first negedge with ACK_to_phys low again, i.e. the first CHECK cycle.
   task automatic phys_respond(input logic [47:0] frame, input bit with_timeout);
      int n;
      bus_if.phys_response = frame;
      bus_if.phys_REQ      = 1'b1;
      bus_if.phys_timeout  = with_timeout;
      n = 0;
      do begin @(negedge CLK_SD_card); n++; end while (bus_if.ACK_to_phys !== 1'b1 && n < 20);
      bus_if.phys_timeout = 1'b0;
      bus_if.phys_REQ     = 1'b0;
      if (bus_if.ACK_to_phys !== 1'b1) begin wait_fail("ack_high"); return; end
      n = 0;
      do begin @(negedge CLK_SD_card); n++; end while (bus_if.ACK_to_phys !== 1'b0 && n < 20);
      bus_if.phys_inactive = 1'b1;
      if (bus_if.ACK_to_phys !== 1'b0) wait_fail("ack_low");
   endtask

   task automatic phys_no_resp(input bit by_rise);
      if (by_rise) bus_if.phys_inactive = 1'b1;
      else bus_if.phys_timeout = 1'b1;
      @(negedge CLK_SD_card);
      bus_if.phys_timeout  = 1'b0;
      bus_if.phys_inactive = 1'b1;
   endtask

   task automatic wait_complete(output int n);
      n = 0;
      while (bus_if.cmd_complete !== 1'b1 && n < 200) begin @(negedge CLK_SD_card); n++; end
      if (bus_if.cmd_complete !== 1'b1) wait_fail("cmd_complete");
   endtask

   task automatic test_reset();
      compared++;
      if ({bus_if.new_cmd, bus_if.REQ_to_phys, bus_if.ACK_to_phys, bus_if.busy,
           bus_if.cmd_complete, errs, bus_if.state_dbg} !== 13'h0) begin
         mismatched++;
         $display("FAIL reset_ctrl: got %b/%b want all zero", errs, bus_if.state_dbg);
      end
      compared++;
      if ({bus_if.resp_data, bus_if.cmd_index_arg} !== 70'h0) begin
         mismatched++;
         $display("FAIL reset_data: got %h/%h want 0/0", bus_if.resp_data, bus_if.cmd_index_arg);
      end
      reset = 1'b0;
      repeat (2) @(negedge CLK_SD_card);
      compared++;
      if ({bus_if.busy, bus_if.new_cmd} !== 2'b00) begin
         mismatched++;
         $display("FAIL reset_idle: got busy=%b new_cmd=%b want 0 0", bus_if.busy, bus_if.new_cmd);
      end
   endtask

   task automatic test_cmd0_none();
      int base, n;
      base = launch_cnt;
      accept(6'd0, 32'h0, 2'b00);
      compared++;
      if ({bus_if.new_cmd, bus_if.busy} !== 2'b11) begin
         mismatched++;
         $display("FAIL accept_latency: got new_cmd=%b busy=%b want 1 1", bus_if.new_cmd, bus_if.busy);
      end
      phys_launch();
      phys_no_resp(1'b0);
      wait_complete(n);
      compared++;
      if (errs !== 5'b00000) begin
         mismatched++;
         $display("FAIL none_errs: got %b want 00000", errs);
      end
      @(negedge CLK_SD_card);
      compared++;
      if (launch_cnt - base !== 1) begin
         mismatched++;
         $display("FAIL none_launches: got %0d want 1", launch_cnt - base);
      end
      compared++;
      if ({bus_if.cmd_complete, bus_if.busy, bus_if.new_cmd} !== 3'b000) begin
         mismatched++;
         $display("FAIL none_after: got complete=%b busy=%b new_cmd=%b want 0 0 0",
                  bus_if.cmd_complete, bus_if.busy, bus_if.new_cmd);
      end
   endtask

   task automatic test_cmd0_r1();
      int n;
      accept(6'd0, 32'h0, 2'b01);
      phys_launch();
      phys_respond(48'h4000000000_95, 1'b0);
      wait_complete(n);
      compared++;
      if (n !== 41) begin
         mismatched++;
         $display("FAIL r1_check_cycles: got %0d want 41", n);
      end
      // 0x40 has the transmission bit set, so only the start-bits check fires.
      compared++;
      if (errs !== 5'b00010) begin
         mismatched++;
         $display("FAIL r1_errs: got %b want 00010", errs);
      end
      compared++;
      if (bus_if.resp_data !== 32'h0) begin
         mismatched++;
         $display("FAIL r1_resp: got %h want 00000000", bus_if.resp_data);
      end
      @(negedge CLK_SD_card);
   endtask

   task automatic test_crc_retry();
      int base, n;
      logic [47:0] good;
      base = launch_cnt;
      accept(6'd0, 32'h0, 2'b01);
      for (int a = 0; a < 3; a++) begin
         phys_launch();
         phys_respond(48'h4000000000_97, 1'b0);
      end
      wait_complete(n);
      compared++;
      if (errs !== 5'b01010) begin
         mismatched++;
         $display("FAIL crc_exhaust_errs: got %b want 01010", errs);
      end
      compared++;
      if (launch_cnt - base !== 3) begin
         mismatched++;
         $display("FAIL crc_exhaust_launches: got %0d want 3", launch_cnt - base);
      end
      @(negedge CLK_SD_card);
      good = make_frame(6'd17, 32'h0000_0900, 1'b1);
      base = launch_cnt;
      accept(6'd17, 32'h0000_0000, 2'b01);
      phys_launch();
      phys_respond(good ^ 48'h2, 1'b0);
      phys_launch();
      phys_respond(good, 1'b0);
      wait_complete(n);
      compared++;
      if (errs !== 5'b00000) begin
         mismatched++;
         $display("FAIL crc_recover_errs: got %b want 00000", errs);
      end
      compared++;
      if (bus_if.resp_data !== 32'h0000_0900) begin
         mismatched++;
         $display("FAIL crc_recover_resp: got %h want 00000900", bus_if.resp_data);
      end
      @(negedge CLK_SD_card);
      compared++;
      if (launch_cnt - base !== 2) begin
         mismatched++;
         $display("FAIL crc_recover_launches: got %0d want 2", launch_cnt - base);
      end
   endtask

   task automatic test_index_endbit();
      int n;
      accept(6'd17, 32'h0000_4000, 2'b11);
      phys_launch();
      // Stray request while busy must not touch the latched command.
      bus_if.cmd_index = 6'd5;
      bus_if.cmd_arg   = 32'hDEAD_BEEF;
      bus_if.resp_type = 2'b10;
      bus_if.start_cmd = 1'b1;
      @(negedge CLK_SD_card);
      bus_if.start_cmd = 1'b0;
      phys_respond(make_frame(6'h10, 32'h0000_0900, 1'b1), 1'b0);
      wait_complete(n);
      compared++;
      if (errs !== 5'b00100) begin
         mismatched++;
         $display("FAIL index_errs: got %b want 00100", errs);
      end
      compared++;
      if (bus_if.cmd_index_arg !== {6'd17, 32'h0000_4000}) begin
         mismatched++;
         $display("FAIL busy_ignore: got %h want %h", bus_if.cmd_index_arg, {6'd17, 32'h0000_4000});
      end
      @(negedge CLK_SD_card);
      accept(6'd17, 32'h0, 2'b01);
      phys_launch();
      phys_respond(make_frame(6'd17, 32'h0000_0900, 1'b0), 1'b0);
      wait_complete(n);
      compared++;
      if (errs !== 5'b00010) begin
         mismatched++;
         $display("FAIL endbit_errs: got %b want 00010", errs);
      end
      @(negedge CLK_SD_card);
   endtask

   task automatic test_r3();
      int base, n;
      base = launch_cnt;
      accept(6'd41, 32'h00FF_8000, 2'b10);
      phys_launch();
      phys_respond(48'h3F_12345678_FF, 1'b1);
      wait_complete(n);
      compared++;
      if (errs !== 5'b00000) begin
         mismatched++;
         $display("FAIL r3_errs: got %b want 00000", errs);
      end
      compared++;
      if (bus_if.resp_data !== 32'h1234_5678) begin
         mismatched++;
         $display("FAIL r3_resp: got %h want 12345678", bus_if.resp_data);
      end
      @(negedge CLK_SD_card);
      compared++;
      if (launch_cnt - base !== 1) begin
         mismatched++;
         $display("FAIL r3_req_priority: got %0d launches want 1", launch_cnt - base);
      end
   endtask

   task automatic test_timeout_retry();
      int base, n;
      base = launch_cnt;
      accept(6'd55, 32'h0, 2'b01);
      for (int a = 0; a < 3; a++) begin
         phys_launch();
         phys_no_resp(1'b1);
      end
      wait_complete(n);
      compared++;
      if (errs !== 5'b10000) begin
         mismatched++;
         $display("FAIL timeout_errs: got %b want 10000", errs);
      end
      @(negedge CLK_SD_card);
      compared++;
      if (launch_cnt - base !== 3) begin
         mismatched++;
         $display("FAIL timeout_launches: got %0d want 3", launch_cnt - base);
      end
   endtask

   task automatic test_watchdog();
      int n;
      accept(6'd8, 32'h0000_01AA, 2'b01);
      phys_launch();
      wait_complete(n);
      compared++;
      if (n !== 8) begin
         mismatched++;
         $display("FAIL hang_cycles: got %0d want 8", n);
      end
      compared++;
      if (errs !== 5'b00001) begin
         mismatched++;
         $display("FAIL hang_errs: got %b want 00001", errs);
      end
      @(negedge CLK_SD_card);
   endtask

   task automatic test_reset_mid();
      int n;
      accept(6'd1, 32'hCAFE_0001, 2'b01);
      bus_if.phys_inactive = 1'b0;
      n = 0;
      while (bus_if.REQ_to_phys !== 1'b1 && n < 20) begin @(negedge CLK_SD_card); n++; end
      if (bus_if.REQ_to_phys !== 1'b1) wait_fail("mid_req");
      reset = 1'b1;
      #1;
      compared++;
      if ({bus_if.REQ_to_phys, bus_if.busy, bus_if.new_cmd, bus_if.ACK_to_phys} !== 4'b0000) begin
         mismatched++;
         $display("FAIL reset_mid_ctrl: got req=%b busy=%b want 0 0", bus_if.REQ_to_phys, bus_if.busy);
      end
      compared++;
      if (bus_if.cmd_index_arg !== 38'h0) begin
         mismatched++;
         $display("FAIL reset_mid_cia: got %h want 0", bus_if.cmd_index_arg);
      end
      @(negedge CLK_SD_card);
      reset = 1'b0;
      bus_if.phys_inactive = 1'b1;
      @(negedge CLK_SD_card);
      compared++;
      if (bus_if.busy !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_mid_idle: got busy=%b want 0", bus_if.busy);
      end
   endtask

   initial begin
      reset                = 1'b1;
      bus_if.start_cmd     = 1'b0;
      bus_if.cmd_index     = 6'd0;
      bus_if.cmd_arg       = 32'h0;
      bus_if.resp_type     = 2'b00;
      bus_if.phys_inactive = 1'b1;
      bus_if.phys_ACK      = 1'b0;
      bus_if.phys_REQ      = 1'b0;
      bus_if.phys_timeout  = 1'b0;
      bus_if.phys_response = 48'h0;
      repeat (3) @(negedge CLK_SD_card);
      test_reset();
      test_cmd0_none();
      test_cmd0_r1();
      test_crc_retry();
      test_index_endbit();
      test_r3();
      test_timeout_retry();
      test_watchdog();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/cmd_sequencer.md
# cmd_sequencer

Sequences one SD command transaction at a time through the CMD physical layer on behalf of the host register block. Latches index, argument and response type, drives the physical layer's new_cmd / REQ / ACK handshakes, and checks the returned 48-bit response for start bits, index, CRC7 and end bit. Retries on timeout or CRC failure, then reports completion or errors upward. Sits between the host command registers and the CMD physical layer, in the SD clock domain.

## Interface
- MAX_RETRY, 2: extra attempts after a timeout or CRC error (0 = no retry).
- WATCHDOG, 255: cycles allowed in WAIT_RESP with no physical-layer event before a hang error.
- CLK_SD_card  in  1  SD clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state and outputs immediately.
- start_cmd  in  1  one-cycle request; accepted only in IDLE, ignored otherwise.
- cmd_index  in  6  command index; latched on accept.
- cmd_arg  in  32  command argument; latched on accept.
- resp_type  in  2  00 none, 01 R1/48-bit checked, 10 R3 (no CRC/index check), 11 treated as 01; latched on accept.
- phys_inactive  in  1  physical layer idle flag.
- phys_ACK  in  1  physical layer ACK (command frame accepted).
- phys_REQ  in  1  physical layer REQ (response ready).
- phys_timeout  in  1  physical layer 64-cycle no-response pulse.
- phys_response  in  48  received response frame.
- new_cmd  out  1  start request to physical layer.
- cmd_index_arg  out  38  {index, arg} to physical layer; held stable from LAUNCH until the physical layer returns to idle.
- REQ_to_phys  out  1  command-ready request.
- ACK_to_phys  out  1  response-taken acknowledge.
- busy  out  1  high in every state except IDLE.
- cmd_complete  out  1  one-cycle pulse at end of transaction.
- resp_data  out  32  response bits [39:8]; valid from the cmd_complete cycle until the next accept.
- err_timeout, err_crc, err_index, err_endbit, err_hang  out  1 each  sticky status; cleared on the next accept.

## Operation
- Reset values: all outputs 0; state IDLE; retry counter 0.
- IDLE: on start_cmd, latch the inputs, clear the error flags, set the retry counter to 0, and go to LAUNCH.
- LAUNCH: new_cmd=1 until phys_inactive=0, then new_cmd=0 and go to HANDSHAKE.
- HANDSHAKE: REQ_to_phys=1 until phys_ACK=1 is sampled, then REQ_to_phys=0 and go to WAIT_RESP.
- WAIT_RESP: the watchdog counts up from 0.
  - phys_REQ=1 -> CAPTURE.
  - phys_timeout=1, or phys_inactive rising without a prior phys_REQ -> TIMEOUT.
  - Watchdog reaches WATCHDOG -> set err_hang -> DONE.
- TIMEOUT:
  - resp_type=00: normal completion, no error -> DONE.
  - Otherwise, if retries < MAX_RETRY: increment the counter -> LAUNCH.
  - Otherwise: set err_timeout -> DONE.
- CAPTURE: latch phys_response into the frame register and assert ACK_to_phys. Hold ACK_to_phys while phys_REQ=1; when phys_REQ=0, drop ACK_to_phys and go to CHECK.
- CHECK:
  - Serial CRC7 (x^7+x^3+1, initial 0) over frame bits [47:8], MSB first, one bit per cycle, 40 cycles.
  - Then compare the result with frame bits [7:1].
  - Checks:
    - Bit 0 != 1 -> err_endbit.
    - Bits [47:46] != 00 -> err_endbit.
    - For types 01/11, bits [45:40] != latched index -> err_index.
    - For types 01/11, CRC mismatch -> CRC fail.
  - CRC fail with retries left: increment the counter -> LAUNCH, with no other flags set.
  - CRC fail with no retries left: set err_crc.
  - Type 10 skips the CRC and index checks.
  - -> DONE.
- DONE: cmd_complete=1 for one cycle, resp_data = frame[39:8] -> IDLE.
- Retry counter width: clog2(MAX_RETRY+1); it never wraps.

## Timing
- Accept: start_cmd sampled in cycle N; new_cmd=1 from cycle N+1.
- Handshake outputs (new_cmd, REQ_to_phys, ACK_to_phys) are registered. Each drops the cycle after its terminating input is sampled.
- CHECK takes exactly 41 cycles (40 shift + 1 compare). cmd_complete follows one cycle after CHECK ends.
- Simultaneous phys_REQ and phys_timeout in WAIT_RESP: phys_REQ wins.
- start_cmd while busy=1: ignored, with no effect on the latched fields.
- reset mid-transaction: the block returns to IDLE asynchronously and all outputs go to 0. The physical layer is reset by the same signal.

## Test plan
- CMD0, arg 0, resp_type 00; physical layer times out -> cmd_complete, all errors 0, retry counter never increments.
- CMD0, arg 0, resp_type 01; response 0x4000000000_95 -> err_crc=0, err_index=0, cmd_complete 41+1 cycles after CAPTURE exit, resp_data=0x00000000.
- Same as above with response 0x4000000000_97 (bad CRC), MAX_RETRY=2 -> 3 LAUNCH entries, then err_crc=1; with a correct response on the 2nd attempt -> no error.
- CMD17, resp_type 01; response index 0x10 -> err_index=1. Response with bit0=0 -> err_endbit=1.
- resp_type 10; response 0x3F_12345678_FF -> no errors, resp_data=0x12345678.
- Hold phys_REQ/phys_timeout low in WAIT_RESP with WATCHDOG=8 -> err_hang after 8 cycles. Assert reset mid-HANDSHAKE -> REQ_to_phys=0 and busy=0 immediately.
